// File: rtl/mux_arbiter_4_if.sv
// Bundle of the requester-facing signals of the 4-way mux arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface mux_arbiter_4_if;
    logic [3:0] req_in;
    logic [3:0] d_in;
    logic       mode_in;
    logic [3:0] gnt_out;
    logic [1:0] sel_out;
    logic       y_out;
    logic       valid_out;
    logic       busy_out;

    modport master (
        output req_in, d_in, mode_in,
        input  gnt_out, sel_out, y_out, valid_out, busy_out
    );

    modport slave (
        input  req_in, d_in, mode_in,
        output gnt_out, sel_out, y_out, valid_out, busy_out
    );
endinterface

// File: rtl/mux_arbiter_4.sv
// Four-requester arbiter for a shared 4:1 one-bit mux: bounded-burst grants,
// fixed-priority (0>3>1>2) or round-robin policy, registered mux output.
module mux_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic            clk_in,
    input  logic            rst_in,
    mux_arbiter_4_if.slave  bus
);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    // Fixed order 0,3,1,2 mirrors the priority-tree mux; round-robin starts after ptr.
    function automatic logic [1:0] pick(input logic [3:0] mask,
                                        input logic       rr_mode,
                                        input logic [1:0] ptr);
        logic [1:0] win;
        logic [1:0] idx;
        logic       found;
        win   = 2'd0;
        idx   = 2'd0;
        found = 1'b0;
        if (!rr_mode) begin
            if      (mask[0]) win = 2'd0;
            else if (mask[3]) win = 2'd3;
            else if (mask[1]) win = 2'd1;
            else              win = 2'd2;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = ptr + 2'(k);
                if (!found && mask[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic [1:0]       r_rr_ptr, w_rr_ptr_nxt;
    logic [CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic             r_y, w_y_nxt;
    logic             r_valid, w_valid_nxt;

    logic [3:0] w_cur_onehot;
    logic       w_expire;
    logic       w_release;
    logic [3:0] w_mask;
    logic [1:0] w_win;

    assign w_cur_onehot = 4'b0001 << r_sel;
    assign w_expire     = (r_hold_cnt == HOLD_LAST);
    assign w_release    = !bus.req_in[r_sel] || w_expire;
    // On hold expiry the current owner steps aside so others get a turn.
    assign w_mask       = (r_state == ST_GRANT && w_expire) ? (bus.req_in & ~w_cur_onehot)
                                                            : bus.req_in;
    assign w_win        = pick(w_mask, bus.mode_in, r_rr_ptr);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_y_nxt        = 1'b0;
        w_valid_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|bus.req_in) begin
                    w_state_nxt    = ST_GRANT;
                    w_sel_nxt      = w_win;
                    w_rr_ptr_nxt   = w_win;
                    w_hold_cnt_nxt = '0;
                end
            end
            ST_GRANT: begin
                w_y_nxt     = bus.d_in[r_sel];
                w_valid_nxt = bus.req_in[r_sel];
                if (!w_release) begin
                    w_hold_cnt_nxt = r_hold_cnt + CNT_W'(1);
                end else if (|w_mask) begin
                    w_sel_nxt      = w_win;
                    w_rr_ptr_nxt   = w_win;
                    w_hold_cnt_nxt = '0;
                end else if (bus.req_in[r_sel]) begin
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_state_nxt    = ST_IDLE;
                    w_hold_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_sel      <= 2'd0;
            r_rr_ptr   <= 2'd3;
            r_hold_cnt <= '0;
            r_y        <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_y        <= w_y_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    assign bus.gnt_out   = (r_state == ST_GRANT) ? w_cur_onehot : 4'b0000;
    assign bus.sel_out   = r_sel;
    assign bus.y_out     = r_y;
    assign bus.valid_out = r_valid;
    assign bus.busy_out  = (r_state == ST_GRANT);

endmodule

// File: tb/tb_mux_arbiter_4.sv
// Bench for mux_arbiter_4: vector table through a scoreboard queue on a
// MAX_HOLD=2 instance, plus reset/fairness sequences on a MAX_HOLD=8 instance.
module tb_mux_arbiter_4;

    typedef struct {
        logic       rst;
        logic       mode;
        logic [3:0] req;
        logic [3:0] d;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       y;
        logic       valid;
        logic       busy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    mux_arbiter_4_if bus_a ();
    mux_arbiter_4_if bus_b ();

    assign bus_b.req_in  = bus_a.req_in;
    assign bus_b.d_in    = bus_a.d_in;
    assign bus_b.mode_in = bus_a.mode_in;

    mux_arbiter_4 #(.MAX_HOLD(2), .CNT_W(8)) dut_a (.clk_in(clk), .rst_in(rst), .bus(bus_a));
    mux_arbiter_4 #(.MAX_HOLD(8), .CNT_W(8)) dut_b (.clk_in(clk), .rst_in(rst), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic [3:0] rq, input logic [3:0] dd);
        @(negedge clk);
        rst           = r;
        bus_a.mode_in = m;
        bus_a.req_in  = rq;
        bus_a.d_in    = dd;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic m, input logic [3:0] rq,
                                input logic [3:0] dd, input logic [3:0] g, input logic [1:0] s,
                                input logic yy, input logic v, input logic b);
        vec_t x;
        x.rst = r; x.mode = m; x.req = rq; x.d = dd;
        x.gnt = g; x.sel = s; x.y = yy; x.valid = v; x.busy = b;
        return x;
    endfunction

    vec_t tbl[$];
    vec_t sb[$];
    vec_t e;
    int   cnt_a[4];
    int   cnt_b[4];
    int   idle_b;

    initial begin
        bus_a.req_in  = 4'b0000;
        bus_a.d_in    = 4'b0000;
        bus_a.mode_in = 1'b0;

        //            rst m  req      d        gnt      sel y  v  busy
        tbl.push_back(mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0)); // reset
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0)); // idle
        tbl.push_back(mk(0, 0, 4'b1110, 4'b0000, 4'b1000, 3, 0, 0, 1)); // fixed: 3 wins
        tbl.push_back(mk(0, 0, 4'b0110, 4'b0000, 4'b0010, 1, 0, 0, 1)); // 3 drops -> 1
        tbl.push_back(mk(0, 0, 4'b0010, 4'b0100, 4'b0010, 1, 0, 1, 1)); // data path
        tbl.push_back(mk(0, 0, 4'b0010, 4'b0110, 4'b0010, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 4'b0010, 4'b0100, 4'b0010, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0010, 4'b0000, 1, 1, 0, 0)); // leave GRANT
        tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0)); // idle output
        tbl.push_back(mk(0, 0, 4'b0100, 4'b0000, 4'b0100, 2, 0, 0, 1)); // grant 2
        tbl.push_back(mk(0, 0, 4'b0001, 4'b0100, 4'b0001, 0, 1, 0, 1)); // release+new req
        tbl.push_back(mk(0, 0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 1, 1)); // sole requester
        tbl.push_back(mk(0, 0, 4'b0001, 4'b0000, 4'b0001, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 4'b0001, 4'b0001, 4'b0001, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 4'b0001, 4'b0000, 4'b0001, 0, 0, 1, 1));
        tbl.push_back(mk(1, 0, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0, 0)); // reset mid-burst
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1010, 4'b0001, 0, 0, 0, 1)); // round-robin
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1010, 4'b0001, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1010, 4'b0010, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1010, 4'b0010, 1, 1, 1, 1));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1010, 4'b0100, 2, 1, 1, 1));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1010, 4'b0100, 2, 0, 1, 1));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1010, 4'b1000, 3, 0, 1, 1));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1010, 4'b1000, 3, 1, 1, 1));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1010, 4'b0001, 0, 1, 1, 1));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1010, 4'b0001, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 4'b1111, 4'b1010, 4'b1000, 3, 0, 1, 1)); // mode switch at arb point
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1010, 4'b1000, 3, 1, 1, 1));
        tbl.push_back(mk(0, 1, 4'b1111, 4'b1010, 4'b0001, 0, 1, 1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            sb.push_back(tbl[i]);
            drive(tbl[i].rst, tbl[i].mode, tbl[i].req, tbl[i].d);
            e = sb.pop_front();
            check($sformatf("v%0d gnt", i),   32'(bus_a.gnt_out),   32'(e.gnt));
            check($sformatf("v%0d sel", i),   32'(bus_a.sel_out),   32'(e.sel));
            check($sformatf("v%0d y", i),     32'(bus_a.y_out),     32'(e.y));
            check($sformatf("v%0d valid", i), 32'(bus_a.valid_out), 32'(e.valid));
            check($sformatf("v%0d busy", i),  32'(bus_a.busy_out),  32'(e.busy));
            check($sformatf("v%0d onehot0", i), 32'($onehot0(bus_a.gnt_out)), 32'd1);
            check($sformatf("v%0d busy_vs_gnt", i), 32'(bus_a.busy_out), 32'(bus_a.gnt_out != 4'b0000));
        end

        // Reset mid-burst on the MAX_HOLD=8 instance: grant 2, hold reaches 3, then reset.
        drive(1, 0, 4'b0000, 4'b0000);
        drive(0, 0, 4'b0100, 4'b0000);
        check("rst_seq first grant", 32'(bus_b.gnt_out), 32'h4);
        for (int i = 0; i < 3; i++) drive(0, 0, 4'b0100, 4'b0000);
        check("rst_seq held gnt", 32'(bus_b.gnt_out), 32'h4);
        drive(1, 0, 4'b0100, 4'b0000);
        check("rst_seq gnt",   32'(bus_b.gnt_out),   32'h0);
        check("rst_seq sel",   32'(bus_b.sel_out),   32'h0);
        check("rst_seq valid", 32'(bus_b.valid_out), 32'h0);
        check("rst_seq busy",  32'(bus_b.busy_out),  32'h0);
        drive(0, 0, 4'b0100, 4'b0000);
        check("rst_seq regrant gnt", 32'(bus_b.gnt_out), 32'h4);
        check("rst_seq regrant sel", 32'(bus_b.sel_out), 32'h2);

        // Round-robin fairness: every 32-cycle window of continuous requests is shared equally.
        for (int k = 0; k < 4; k++) begin
            cnt_a[k] = 0;
            cnt_b[k] = 0;
        end
        idle_b = 0;
        drive(0, 1, 4'b1111, 4'b0000);
        for (int i = 0; i < 32; i++) begin
            drive(0, 1, 4'b1111, 4'b0000);
            for (int k = 0; k < 4; k++) begin
                if (bus_a.gnt_out[k]) cnt_a[k]++;
                if (bus_b.gnt_out[k]) cnt_b[k]++;
            end
            if (!bus_b.busy_out) idle_b++;
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fair_a req%0d", k), 32'(cnt_a[k]), 32'd8);
            check($sformatf("fair_b req%0d", k), 32'(cnt_b[k]), 32'd8);
        end
        check("fair_b no idle", 32'(idle_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_4.md
Name: mux_arbiter_4

Overview:
- Four-requester arbiter and scheduler for the shared 4:1 one-bit data mux.
- Decides which requester owns the mux, drives its 2-bit select, and registers the muxed bit.
- Holds a grant for a bounded burst; then re-arbitrates.
- Two selectable policies:
  - Fixed priority, in the same order as the team's priority-tree mux (0, 3, 1, 2).
  - Round-robin.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles for one requester before forced re-arbitration (range 1..255).
- CNT_W, 8: width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk_in  input  1  single clock; all state changes on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- req_in  input  4  per-requester request; bit i = requester i.
- d_in  input  4  per-requester data bit; bit i sourced by requester i.
- mode_in  input  1  0 = fixed priority (0 > 3 > 1 > 2); 1 = round-robin. Sampled only at arbitration points.
- gnt_out  output  4  one-hot grant; all zero when idle.
- sel_out  output  2  encoded index of the granted requester (mux select).
- y_out  output  1  registered mux output.
- valid_out  output  1  y_out carries a valid granted bit.
- busy_out  output  1  high while in state GRANT.

Behaviour:
- Reset, with rst_in=1 at an edge (overrides everything, including mid-burst):
  - state=IDLE; gnt_out=0000; sel_out=00; y_out=0; valid_out=0; busy_out=0; hold_cnt=0; rr_ptr=3, so the first round-robin search starts at requester 0.
- Arbitration function pick(mask):
  - Fixed mode: first set bit of mask in order 0, 3, 1, 2.
  - Round-robin mode: first set bit searching (rr_ptr+1), (rr_ptr+2), ... mod 4.
- State IDLE:
  - If req_in != 0: next edge goes to GRANT with w = pick(req_in); gnt_out=onehot(w), sel_out=w, hold_cnt=0, rr_ptr=w.
  - Otherwise remain in IDLE with outputs at their reset values.
- State GRANT, with current winner c = sel_out:
  - Data path, every edge: y_out <= d_in[c]; valid_out <= req_in[c]. Latency from d_in to y_out is 1 cycle.
  - Release condition R = (req_in[c]==0) OR (hold_cnt==MAX_HOLD-1).
  - If R is false: hold_cnt <= hold_cnt+1; grant unchanged.
  - If R is true, the candidate mask is:
    - req_in with bit c cleared, when the release is due to hold expiry;
    - req_in otherwise (bit c is 0 anyway).
  - If the candidate mask is non-zero: the next edge grants w = pick(mask) directly, with no idle bubble; hold_cnt=0, rr_ptr=w.
  - If the mask is zero and req_in[c]=1 (hold expiry, sole requester): re-grant c; hold_cnt=0.
  - If the mask is zero and req_in=0: go to IDLE; gnt_out=0000; sel_out keeps its last value.
- valid_out and y_out on the edge that leaves GRANT:
  - Both follow the rule above for c.
  - One cycle after entering IDLE, valid_out=0 and y_out=0.
- Simultaneous events:
  - A request rising on the same edge as a release participates in that arbitration.
  - A mode_in change mid-burst takes effect only at the next arbitration point.
- Changes in req_in of non-granted requesters never pre-empt the current grant before R.
- Invariants:
  - gnt_out is always one-hot or zero.
  - gnt_out==onehot(sel_out) whenever busy_out=1.
  - busy_out==(gnt_out!=0).
- Round-robin fairness: with all four requesting continuously, each requester receives exactly MAX_HOLD cycles per 4*MAX_HOLD-cycle window.

Test Plan:
- Reset mid-burst:
  - Stimulus: grant to requester 2 with hold_cnt=3; assert rst_in for 1 cycle.
  - Required: next cycle gnt_out=0000, sel_out=00, valid_out=0, busy_out=0; with req_in=0100 held, the re-grant to 2 follows 1 cycle after rst_in falls.
- Fixed priority:
  - Stimulus: mode_in=0, req_in=1110 from IDLE.
  - Required: gnt_out=1000 (requester 3) after 1 edge.
  - Then req_in=0110 with requester 3 dropped: the next grant is 0010 (requester 1), with no idle cycle.
- Round-robin with MAX_HOLD=2:
  - Stimulus: mode_in=1, req_in=1111 held.
  - Required: sel_out sequence 0,0,1,1,2,2,3,3,0,0…; busy_out constant 1.
- Hold expiry with sole requester, MAX_HOLD=2:
  - Stimulus: only req_in=0001.
  - Required: gnt_out stays 0001 continuously; hold_cnt wraps 0,1,0,1…
- Data path:
  - Stimulus: granted to 1, d_in toggled 0100 → 0110 → 0100.
  - Required: y_out = 0,1,0 each 1 cycle later with valid_out=1; then drop req_in[1] → valid_out=0 on the following cycle and return to IDLE.
- Simultaneous release and new request:
  - Stimulus: mode_in=0, requester 2 granted; on the same edge req_in goes from 0100 to 0001.
  - Required: gnt_out=0001 at that edge + 1; never 0000 in between.
